// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the multiplexed 7-segment display path:
//   - state_t   : scan FSM encoding (ST_BLANK / ST_SHOW)
//   - SEG_OFF   : all-segments-dark pattern
//   - SEG_TABLE : hex 0..F to 9-bit segment pattern, bits [6:0] = a..g,
//                 bit 7 = dp (always 0 here), bit 8 = 0
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [8:0] SEG_OFF = 9'h000;

  // Packed so that SEG_TABLE[n] is the pattern for hex digit n; entry 15 first.
  localparam logic [15:0][8:0] SEG_TABLE = {
    9'h071, 9'h079, 9'h05E, 9'h039,   // F E D C
    9'h07C, 9'h077, 9'h06F, 9'h07F,   // B A 9 8
    9'h007, 9'h07D, 9'h06D, 9'h066,   // 7 6 5 4
    9'h04F, 9'h05B, 9'h006, 9'h03F    // 3 2 1 0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Combinational hex nibble to 7-segment lookup.
// Ports:
//   nibble : in  [3:0] hex value
//   seg    : out [8:0] active-high pattern, [6:0] = a..g, [8:7] = 0
// -----------------------------------------------------------------------------
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [8:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexes DIGITS hex nibbles onto one 7-segment decoder and a
// common-anode digit-select bus. Every slot is SLOT_CYC = CLK_HZ/SCAN_HZ
// cycles: BLANK_CYC cycles with all digits off, then the digit is shown.
// New data is captured on a load strobe into pending registers and copied to
// the shadow (displayed) registers only at a frame boundary.
//
// Optional feature macro: SEG_SCAN_DP_EN adds a per-digit decimal point input
// (dp_in) carried through the same pending/shadow path.
//
// Ports:
//   clk        : in  system clock
//   rst        : in  synchronous active-high reset
//   load       : in  one-cycle strobe, capture data_in/blank_mask (and dp_in)
//   data_in    : in  [4*DIGITS-1:0] nibble i at [4i+3:4i], digit 0 rightmost
//   blank_mask : in  [DIGITS-1:0] bit i forces digit i dark
//   dp_in      : in  [DIGITS-1:0] decimal points (SEG_SCAN_DP_EN only)
//   lz_en      : in  leading-zero suppression enable, sampled at SHOW entry
//   seg_led    : out [8:0] active-high segments, [6:0] a..g, [7] dp, [8] 0
//   dig_sel    : out [DIGITS-1:0] active-low one-hot digit enable
//   frame_done : out one-cycle pulse when the last slot of a frame ends
//   load_ack   : out one-cycle pulse when the shadow registers take new data
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     blank_mask,
`ifdef SEG_SCAN_DP_EN
  input  logic [DIGITS-1:0]     dp_in,
`endif
  input  logic                  lz_en,
  output logic [8:0]            seg_led,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done,
  output logic                  load_ack
);

  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_ctrl: DIGITS must be in 1..8");
  end
  if (SLOT_CYC < 2) begin : g_bad_slot
    $error("seg_scan_ctrl: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (BLANK_CYC < 1 || BLANK_CYC >= SLOT_CYC) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYC must satisfy 1 <= BLANK_CYC < SLOT_CYC");
  end

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;

  logic [4*DIGITS-1:0]   shadow_data, pend_data;
  logic [DIGITS-1:0]     shadow_mask, pend_mask;
  logic                  pending;
  logic [DIGITS-1:0]     shadow_dp;
`ifdef SEG_SCAN_DP_EN
  logic [DIGITS-1:0]     pend_dp;
`endif

  logic                  blank_end, slot_end, frame_end;
  logic [3:0]            cur_nibble;
  logic                  cur_dark;
  logic                  cur_dp;
  logic [DIGITS-1:0]     lz_dark;
  logic                  zero_above;
  logic [8:0]            dec_seg;

  assign blank_end = (state == ST_BLANK) && (cnt == CNT_W'(BLANK_CYC - 1));
  assign slot_end  = (state == ST_SHOW)  && (cnt == CNT_W'(SLOT_CYC - 1));
  assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));

  // Leading-zero mask: a digit is a candidate if it and every higher nibble
  // are zero. Digit 0 always shows so a zero value still reads "0"; a digit
  // with its decimal point lit is never suppressed.
  // NOTE: always_comb uses blocking '=' so zero_above accumulates in loop
  // order within one evaluation; sequential state below uses '<=' instead.
  always_comb begin
    // NOTE: every always_comb output is given a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    zero_above = 1'b1;
    lz_dark    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (shadow_data[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_above && (i != 0) && !shadow_dp[i];
    end
  end

  // Select the nibble, mask and dp of the digit about to be shown.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dark   = 1'b0;
    cur_dp     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = shadow_data[4*i +: 4];
        cur_dark   = shadow_mask[i] || (lz_en && lz_dark[i]);
        cur_dp     = shadow_dp[i];
      end
    end
  end

  seg_hex_decode u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifndef SEG_SCAN_DP_EN
  assign shadow_dp = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow/pending registers are plain flops, not a RAM, so
      // clearing them in reset is cheap and makes the first frame defined.
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_mask <= '0;
      pend_data   <= '0;
      pend_mask   <= '0;
      pending     <= 1'b0;
      seg_led     <= SEG_OFF;
      dig_sel     <= '1;
      frame_done  <= 1'b0;
      load_ack    <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      shadow_dp   <= '0;
      pend_dp     <= '0;
`endif
    end else begin
      frame_done <= frame_end;
      load_ack   <= 1'b0;
      cnt        <= slot_end ? '0 : cnt + 1'b1;

      // Outputs only move on the two FSM transitions, so seg_led and dig_sel
      // always change together; lz_en is therefore sampled at SHOW entry.
      if (blank_end) begin
        state <= ST_SHOW;
        if (cur_dark) begin
          seg_led <= SEG_OFF;
          dig_sel <= '1;
        end else begin
          seg_led <= {dec_seg[8], cur_dp, dec_seg[6:0]};
          dig_sel <= ~(DIGITS'(1) << idx);
        end
      end else if (slot_end) begin
        state   <= ST_BLANK;
        idx     <= frame_end ? '0 : idx + 1'b1;
        seg_led <= SEG_OFF;
        dig_sel <= '1;
      end

      // Load handshake. A load in the frame-end cycle goes straight to the
      // shadow registers so it is not deferred by a whole frame.
      if (frame_end) begin
        if (load) begin
          shadow_data <= data_in;
          shadow_mask <= blank_mask;
`ifdef SEG_SCAN_DP_EN
          shadow_dp   <= dp_in;
`endif
          load_ack    <= 1'b1;
        end else if (pending) begin
          shadow_data <= pend_data;
          shadow_mask <= pend_mask;
`ifdef SEG_SCAN_DP_EN
          shadow_dp   <= pend_dp;
`endif
          load_ack    <= 1'b1;
        end
        pending <= 1'b0;
      end else if (load) begin
        pend_data <= data_in;
        pend_mask <= blank_mask;
`ifdef SEG_SCAN_DP_EN
        pend_dp   <= dp_in;
`endif
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with DIGITS=4, SLOT_CYC=10, BLANK_CYC=2.
// Offsets below are cycles from the first cycle of a frame (the cycle in
// which frame_done is high); digit k is shown at offsets 10k+2 .. 10k+9.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [8:0]  seg_led;
  logic [3:0]  dig_sel;
  logic        frame_done;
  logic        load_ack;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  dp_in;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS    (4),
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .blank_mask (blank_mask),
`ifdef SEG_SCAN_DP_EN
    .dp_in      (dp_in),
`endif
    .lz_en      (lz_en),
    .seg_led    (seg_led),
    .dig_sel    (dig_sel),
    .frame_done (frame_done),
    .load_ack   (load_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next frame start, counting load_ack pulses on the way.
  task automatic wait_frame(output bit found, output int acks);
    found = 1'b0;
    acks  = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      tick();
      if (load_ack === 1'b1) acks++;
      if (frame_done === 1'b1) found = 1'b1;
    end
  endtask

  // From a frame start, check every digit in its SHOW phase; ends at offset 32.
  task automatic show_digits(input string name,
                             input logic [3:0][8:0] es,
                             input logic [3:0][3:0] ed);
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 2 : 10) tick();
      total++;
      if (seg_led !== es[k] || dig_sel !== ed[k]) begin
        bad++;
        $display("FAIL %s digit%0d: seg_led=%h dig_sel=%b, expected seg_led=%h dig_sel=%b",
                 name, k, seg_led, dig_sel, es[k], ed[k]);
      end
    end
  endtask

  // From offset 32, load in the frame-end cycle (offset 39); the transfer
  // must happen at that same boundary.
  task automatic load_at_boundary(input string name, input logic [15:0] d,
                                  input logic [3:0] m, input logic [3:0] dp);
    repeat (7) tick();
    load       = 1'b1;
    data_in    = d;
    blank_mask = m;
`ifdef SEG_SCAN_DP_EN
    dp_in      = dp;
`else
    if (dp != 4'b0000) $display("note: dp ignored without SEG_SCAN_DP_EN");
`endif
    tick();
    load = 1'b0;
    total++;
    if (frame_done !== 1'b1 || load_ack !== 1'b1) begin
      bad++;
      $display("FAIL %s boundary: frame_done=%b load_ack=%b, expected 1 1",
               name, frame_done, load_ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; data_in = '0; blank_mask = '0; lz_en = 1'b0;
`ifdef SEG_SCAN_DP_EN
    dp_in = '0;
`endif
    tick(); tick();
    total++;
    if (seg_led !== 9'h000 || dig_sel !== 4'b1111 || frame_done !== 1'b0 || load_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset: seg=%h sel=%b fd=%b ack=%b, expected 000 1111 0 0",
               seg_led, dig_sel, frame_done, load_ack);
    end
    rst = 1'b0;
    tick();   // cycle 1, still BLANK
    total++;
    if (seg_led !== 9'h000 || dig_sel !== 4'b1111) begin
      bad++;
      $display("FAIL idle_blank: seg=%h sel=%b, expected 000 1111", seg_led, dig_sel);
    end
    tick();   // cycle 2, first SHOW
    total++;
    if (seg_led !== 9'h03F || dig_sel !== 4'b1110) begin
      bad++;
      $display("FAIL first_show: seg=%h sel=%b, expected 03f 1110", seg_led, dig_sel);
    end
    repeat (37) tick();   // cycle 39
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL frame_early: frame_done=%b at cycle 39, expected 0", frame_done);
    end
    tick();               // cycle 40
    total++;
    if (frame_done !== 1'b1 || load_ack !== 1'b0) begin
      bad++;
      $display("FAIL frame_40: frame_done=%b load_ack=%b, expected 1 0", frame_done, load_ack);
    end
  endtask

  task automatic test_load();
    bit found;
    int acks;
    repeat (15) tick();   // offset 15, digit 1 SHOW
    load = 1'b1; data_in = 16'h1234; blank_mask = 4'b0000;
    tick();
    load = 1'b0;
    total++;
    if (seg_led !== 9'h03F || dig_sel !== 4'b1101 || load_ack !== 1'b0) begin
      bad++;
      $display("FAIL load_hold: seg=%h sel=%b ack=%b, expected 03f 1101 0",
               seg_led, dig_sel, load_ack);
    end
    wait_frame(found, acks);
    total++;
    if (!found || acks != 1 || load_ack !== 1'b1) begin
      bad++;
      $display("FAIL load_ack: found=%0d acks=%0d ack_now=%b, expected 1 1 1", found, acks, load_ack);
    end
    show_digits("data_1234", {9'h006, 9'h05B, 9'h04F, 9'h066},
                {4'b0111, 4'b1011, 4'b1101, 4'b1110});
  endtask

  task automatic test_back_to_back();
    bit found;
    int acks;
    tick();   // offset 33
    load = 1'b1; data_in = 16'hAAAA;
    tick();
    data_in = 16'h00C5;
    tick();
    load = 1'b0;
    wait_frame(found, acks);
    total++;
    if (!found || acks != 1 || load_ack !== 1'b1) begin
      bad++;
      $display("FAIL last_wins_ack: found=%0d acks=%0d ack_now=%b, expected 1 1 1", found, acks, load_ack);
    end
    show_digits("data_00c5", {9'h03F, 9'h03F, 9'h039, 9'h06D},
                {4'b0111, 4'b1011, 4'b1101, 4'b1110});
  endtask

  task automatic test_lz();
    lz_en = 1'b1;
    load_at_boundary("lz_0005", 16'h0005, 4'b0000, 4'b0000);
    show_digits("lz_0005", {9'h000, 9'h000, 9'h000, 9'h06D},
                {4'b1111, 4'b1111, 4'b1111, 4'b1110});
    load_at_boundary("lz_0000", 16'h0000, 4'b0000, 4'b0000);
    show_digits("lz_0000", {9'h000, 9'h000, 9'h000, 9'h03F},
                {4'b1111, 4'b1111, 4'b1111, 4'b1110});
    lz_en = 1'b0;
  endtask

  task automatic test_blank_mask();
    load_at_boundary("mask_8888", 16'h8888, 4'b0100, 4'b0000);
    show_digits("mask_8888", {9'h07F, 9'h000, 9'h07F, 9'h07F},
                {4'b0111, 4'b1111, 4'b1101, 4'b1110});
  endtask

  task automatic test_reset_mid();
    bit found;
    int acks;
    repeat (8) tick();    // offset 40 = next frame start
    repeat (12) tick();   // offset 12, digit 1 SHOW
    total++;
    if (dig_sel !== 4'b1101) begin
      bad++;
      $display("FAIL pre_reset_show: sel=%b, expected 1101", dig_sel);
    end
    load = 1'b1; data_in = 16'h1111; blank_mask = 4'b0000;
    tick();
    load = 1'b0;
    rst  = 1'b1;
    tick();
    total++;
    if (seg_led !== 9'h000 || dig_sel !== 4'b1111 || frame_done !== 1'b0 || load_ack !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: seg=%h sel=%b fd=%b ack=%b, expected 000 1111 0 0",
               seg_led, dig_sel, frame_done, load_ack);
    end
    rst = 1'b0;
    tick(); tick();       // cycle 2, shadow cleared by reset
    total++;
    if (seg_led !== 9'h03F || dig_sel !== 4'b1110) begin
      bad++;
      $display("FAIL post_reset_show: seg=%h sel=%b, expected 03f 1110", seg_led, dig_sel);
    end
    wait_frame(found, acks);
    total++;
    if (!found || acks != 0) begin
      bad++;
      $display("FAIL discard_pending: found=%0d acks=%0d, expected 1 0", found, acks);
    end
  endtask

`ifdef SEG_SCAN_DP_EN
  task automatic test_dp();
    repeat (32) tick();
    lz_en = 1'b1;
    load_at_boundary("dp_0000", 16'h0000, 4'b0000, 4'b0010);
    show_digits("dp_0000", {9'h000, 9'h000, 9'h0BF, 9'h03F},
                {4'b1111, 4'b1111, 4'b1101, 4'b1110});
    lz_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_lz();
    test_blank_mask();
    test_reset_mid();
`ifdef SEG_SCAN_DP_EN
    test_dp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
